// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits a
// fixed LATENCY, commits the access on the WAIT->RESP edge, then holds the
// response until the requester takes it. Storage is not reset.
module dmem_responder #(
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned DEPTH_BITS   = 10,
  parameter int unsigned LATENCY      = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDRESS_BITS-1:0] req_addr,
  input  logic [31:0]             req_wdata,
  input  logic [3:0]              req_byte_en,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_error,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic                    r_wen;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [31:0]             r_wdata;
  logic [3:0]              r_byte_en;
  logic [31:0]             r_rdata;
  logic                    r_err;
  logic                    w_accept;
  logic                    w_commit;
  logic                    w_err;
  logic [DEPTH_BITS-1:0]   w_idx;

  logic [31:0] r_mem [0:(2**DEPTH_BITS)-1];

  // Misaligned or beyond-storage addresses fault; the shift covers the case
  // where no upper address bits exist above the word index.
  assign w_err = (r_addr[1:0] != 2'b00) || ((r_addr >> (DEPTH_BITS + 2)) != '0);
  assign w_idx = r_addr[DEPTH_BITS+1:2];

  assign rsp_rdata = r_rdata;
  assign rsp_error = r_err;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake/status outputs
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_commit  = 1'b0;
    req_ready = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_commit = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, latency countdown and response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_byte_en <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wen     <= req_wen;
        r_addr    <= req_addr;
        r_wdata   <= req_wdata;
        r_byte_en <= req_byte_en;
        r_cnt     <= 4'(LATENCY - 1);
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rdata <= (!r_wen && !w_err) ? r_mem[w_idx] : '0;
        r_err   <= w_err;
      end
    end
  end

  // Byte-lane store commit; w_commit is low whenever the FSM sits in reset,
  // so an interrupted store never reaches storage.
  always_ff @(posedge clock) begin
    if (w_commit && r_wen && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_byte_en[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDRESS_BITS=16, DEPTH_BITS=10, LATENCY=2).
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byte_en;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  dmem_responder #(
    .ADDRESS_BITS(16),
    .DEPTH_BITS(10),
    .LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen(req_wen),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_byte_en(req_byte_en),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: accept, measure latency, optionally stall the response
  // for `hold` cycles while poking ignored requests, then hand it off.
  task automatic txn(input string tag, input logic wen, input logic [15:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    logic [31:0] held;
    @(negedge clock);
    chk({tag, "/ready_before"}, 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_wen     = wen;
    req_addr    = addr;
    req_wdata   = wdata;
    req_byte_en = be;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk({tag, "/busy_after_accept"}, {30'd0, busy, req_ready}, 32'd2);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'(LAT));
    chk({tag, "/rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "/error"}, 32'(rsp_error), 32'(exp_err));
    held = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      req_valid   = (k % 2) == 0;
      req_wen     = 1'b1;
      req_addr    = 16'h0030;
      req_wdata   = 32'h99999999;
      req_byte_en = 4'hF;
      @(posedge clock);
      #1;
      chk({tag, "/stall_state"}, {29'd0, rsp_valid, req_ready, busy}, 32'd5);
      chk({tag, "/stall_rdata"}, rsp_rdata, held);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "/after_handshake"}, {29'd0, rsp_valid, req_ready, busy}, 32'd2);
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_wen     = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_byte_en = '0;
    rsp_ready   = 1'b0;

    #2;
    chk("reset_outputs", {28'd0, req_ready, busy, rsp_valid, rsp_error}, 32'h8);
    chk("reset_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Full-word store then load
    txn("st_deadbeef", 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
    txn("ld_deadbeef", 1'b0, 16'h0010, 32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0);
    // Single-lane store merges
    txn("st_lane0",    1'b1, 16'h0010, 32'h000000AA, 4'h1, 0, 32'h0, 1'b0);
    txn("ld_lane0",    1'b0, 16'h0010, 32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0);
    // Empty byte-enable completes and changes nothing
    txn("st_be0",      1'b1, 16'h0010, 32'h11223344, 4'h0, 0, 32'h0, 1'b0);
    txn("ld_be0",      1'b0, 16'h0010, 32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0);
    // Faulting loads
    txn("ld_misalign", 1'b0, 16'h0012, 32'h0,        4'h0, 0, 32'h0, 1'b1);
    txn("ld_range",    1'b0, 16'h1000, 32'h0,        4'h0, 0, 32'h0, 1'b1);
    txn("ld_after_err",1'b0, 16'h0010, 32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0);
    // Faulting store must not alias onto word 0
    txn("st_word0",    1'b1, 16'h0000, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0);
    txn("st_range",    1'b1, 16'h1000, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1);
    txn("st_misalign", 1'b1, 16'h0001, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1);
    txn("ld_word0",    1'b0, 16'h0000, 32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0);
    // Response stall with ignored request pulses
    txn("st_30",       1'b1, 16'h0030, 32'h11111111, 4'hF, 0, 32'h0, 1'b0);
    txn("ld_30_stall", 1'b0, 16'h0030, 32'h0,        4'h0, 5, 32'h11111111, 1'b0);
    txn("ld_30_again", 1'b0, 16'h0030, 32'h0,        4'h0, 0, 32'h11111111, 1'b0);

    // Reset in WAIT discards an in-flight store
    txn("st_20_zero",  1'b1, 16'h0020, 32'h00000000, 4'hF, 0, 32'h0, 1'b0);
    txn("ld_30_pre",   1'b0, 16'h0030, 32'h0,        4'h0, 0, 32'h11111111, 1'b0);
    @(negedge clock);
    req_valid   = 1'b1;
    req_wen     = 1'b1;
    req_addr    = 16'h0020;
    req_wdata   = 32'h12345678;
    req_byte_en = 4'hF;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk("rst_wait_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_outputs", {28'd0, req_ready, busy, rsp_valid, rsp_error}, 32'h8);
    chk("rst_async_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_held_outputs", {28'd0, req_ready, busy, rsp_valid, rsp_error}, 32'h8);
    @(negedge clock);
    reset = 1'b1;
    txn("ld_20_after_rst", 1'b0, 16'h0020, 32'h0, 4'h0, 0, 32'h00000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 16, byte-address width of req_addr.
REQ-002 SHALL have parameter DEPTH_BITS, default 10, log2 of storage depth in 32-bit words; legal only when ADDRESS_BITS >= DEPTH_BITS+2.
REQ-003 SHALL have parameter LATENCY, default 2, accept-to-response cycles, legal range 1..15.
REQ-004 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_wen  input  1  1=store, 0=load.
REQ-009 SHALL have port req_addr  input  ADDRESS_BITS  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data.
REQ-011 SHALL have port req_byte_en  input  4  store byte lanes; bit i enables bits 8i+7:8i.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  requester accepts response.
REQ-014 SHALL have port rsp_rdata  output  32  load data.
REQ-015 SHALL have port rsp_error  output  1  request faulted.
REQ-016 SHALL have port busy  output  1  transaction in flight.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; one outstanding transaction maximum.
REQ-018 SHALL drive req_ready=1 only in IDLE; busy=1 in WAIT and RESP.
REQ-019 SHALL accept a request on an edge where req_valid=1 and req_ready=1, capturing req_wen, req_addr, req_wdata, req_byte_en; inputs are ignored at all other times.
REQ-020 SHALL on acceptance enter WAIT with counter=LATENCY-1; in WAIT decrement each edge; on edge with counter=0 go to RESP.
REQ-021 SHALL assert rsp_valid exactly LATENCY edges after the acceptance edge (rsp_valid high in the cycle after edge N+LATENCY-1... i.e. first high after edge N+LATENCY).
REQ-022 SHALL flag error when captured addr[1:0]!=0 or addr[ADDRESS_BITS-1:DEPTH_BITS+2]!=0.
REQ-023 SHALL, on the WAIT->RESP edge, for a non-error store, write only enabled byte lanes of word addr[DEPTH_BITS+1:2]; byte_en=0000 writes nothing and completes normally.
REQ-024 SHALL, on the WAIT->RESP edge, register rsp_rdata = stored word for non-error load, 0 for stores and all errors; rsp_error = error flag.
REQ-025 SHALL never modify storage for an errored request.
REQ-026 SHALL hold rsp_valid, rsp_rdata, rsp_error stable in RESP until rsp_ready=1.
REQ-027 SHALL on an edge with rsp_valid=1 and rsp_ready=1 return to IDLE; req_ready rises the following cycle (no same-cycle accept), giving a minimum of LATENCY+2 cycles per transaction.
REQ-028 SHALL return a load issued after a store to the same word with the stored data (store committed before load accepted).

Reset
REQ-029 SHALL, while reset=0, force state=IDLE, counter=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, independent of clock.
REQ-030 SHALL discard any in-flight transaction on reset; a store not yet at its WAIT->RESP edge SHALL NOT modify storage.
REQ-031 SHALL NOT reset storage contents.

Verification
REQ-032 LATENCY=2: store 0xDEADBEEF, be=1111 to 0x0010, then load 0x0010 -> rsp_valid 2 edges after each accept, load rdata=0xDEADBEEF, rsp_error=0.
REQ-033 Store 0x000000AA be=0001 to 0x0010 over 0xDEADBEEF, load -> rdata=0xDEADBEAA.
REQ-034 Load 0x0012 and load 0x1000 (DEPTH_BITS=10) -> rsp_error=1, rdata=0; prior word 0x0010 unchanged.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0 throughout, req_valid pulses ignored; req_ready=1 one cycle after handshake.
REQ-036 Store 0x12345678 to 0x0020 (old 0x0), reset=0 pulse in WAIT -> outputs at reset values immediately; later load 0x0020 -> 0x00000000.
